// File: rtl/add4simd_sched.sv
// add4simd_sched: gathers up to four scalar 12-bit add requests, packs them
// into one 4-lane SIMD operation on a shared adder, captures the packed sum
// after LAT cycles and hands the lane sums back out one at a time with tags.
module add4simd_sched #(
  parameter int TAG_W   = 4,
  parameter int LAT     = 1,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [47:0]      simd_a,
  output logic [47:0]      simd_b,
  output logic             simd_issue,
  input  logic [47:0]      simd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_sum,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C    = 3'(LAT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t r_state;
  state_t w_next;

  // Lane 0 sits at the top of each packed array, matching the adder's lane map.
  logic [0:3][11:0]      r_a;
  logic [0:3][11:0]      r_b;
  logic [0:3][11:0]      r_res;
  logic [0:3][TAG_W-1:0] r_tag;
  logic [3:0]            r_mask;
  logic [2:0]            r_count;
  logic [7:0]            r_timer;
  logic [2:0]            r_wait;
  logic [1:0]            r_lane;

  logic       w_accept;
  logic       w_full;
  logic       w_batch;
  logic       w_capture;
  logic       w_pop;
  logic       w_last;
  logic [1:0] w_lane_nx;

  // Handshake strobes are qualified by ce so a frozen block never transfers.
  assign in_ready   = ce & ~rst & (r_state == S_FILL);
  assign simd_issue = ce & (r_state == S_ISSUE);
  assign out_valid  = ce & (r_state == S_DRAIN);

  // Lane registers feed the adder directly; unused lanes stay cleared.
  assign simd_a  = r_a;
  assign simd_b  = r_b;
  assign out_sum = r_res[r_lane];
  assign out_tag = r_tag[r_lane];

  assign w_accept  = in_valid & in_ready;
  assign w_full    = w_accept & (r_count == 3'd3);
  assign w_batch   = (r_count != 3'd0) & ((r_timer == TMO_LAST) | flush);
  assign w_capture = ((r_state == S_ISSUE) & (LAT_C == 3'd0)) |
                     ((r_state == S_WAIT) & (r_wait == LAT_C));
  assign w_pop     = out_valid & out_ready;
  assign w_lane_nx = r_lane + 2'd1;
  assign w_last    = (r_lane == 2'd3) | ~r_mask[w_lane_nx];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  // Next-state decode for the fill / issue / wait / drain sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FILL: begin
        if (ce & (w_full | w_batch)) w_next = S_ISSUE;
        else                         w_next = S_FILL;
      end
      S_ISSUE: begin
        if (!ce)                   w_next = S_ISSUE;
        else if (LAT_C == 3'd0)    w_next = S_DRAIN;
        else                       w_next = S_WAIT;
      end
      S_WAIT: begin
        if (ce & w_capture) w_next = S_DRAIN;
        else                w_next = S_WAIT;
      end
      S_DRAIN: begin
        if (w_pop & w_last) w_next = S_FILL;
        else                w_next = S_DRAIN;
      end
      default: w_next = S_FILL;
    endcase
  end

  // Batch datapath: lane fill, partial-batch timer, latency count, capture, drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= 48'd0;
      r_b     <= 48'd0;
      r_res   <= 48'd0;
      r_tag   <= '0;
      r_mask  <= 4'd0;
      r_count <= 3'd0;
      r_timer <= 8'd0;
      r_wait  <= 3'd0;
      r_lane  <= 2'd0;
    end else if (ce) begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_a[r_count[1:0]]    <= in_a;
            r_b[r_count[1:0]]    <= in_b;
            r_tag[r_count[1:0]]  <= in_tag;
            r_mask[r_count[1:0]] <= 1'b1;
            r_count              <= r_count + 3'd1;
          end
          if (r_count == 3'd0) r_timer <= 8'd0;
          else                 r_timer <= r_timer + 8'd1;
          r_wait <= 3'd1;
          r_lane <= 2'd0;
        end
        S_ISSUE: begin
          if (w_capture) r_res <= simd_result;
        end
        S_WAIT: begin
          if (w_capture) r_res  <= simd_result;
          else           r_wait <= r_wait + 3'd1;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (w_last) begin
              r_a     <= 48'd0;
              r_b     <= 48'd0;
              r_mask  <= 4'd0;
              r_count <= 3'd0;
              r_timer <= 8'd0;
              r_lane  <= 2'd0;
            end else begin
              r_lane <= w_lane_nx;
            end
          end
        end
        default: r_lane <= r_lane;
      endcase
    end
  end

endmodule

// File: tb/tb_add4simd_sched.sv
// Directed bench for add4simd_sched: three instances (LAT=1, 0, 4) share the
// stimulus, one selected at a time, each with its own ce-gated adder model
// that only shows the true sum in the exact capture cycle.
module tb_add4simd_sched;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, flush, out_ready;
  logic [11:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [1:0]  sel;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int issue_cnt = 0;

  localparam logic [47:0] BAD = 48'hBADBADBADBAD;

  always #5 clk = ~clk;

  function automatic logic [47:0] lane_add(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    for (int i = 0; i < 4; i++) r[i*12 +: 12] = a[i*12 +: 12] + b[i*12 +: 12];
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 1) ? 0 : ((g == 2) ? 4 : 1);
    localparam logic [1:0] G = 2'(g);
    logic        rdy, iss, ov;
    logic [47:0] sa, sb, res;
    logic [11:0] sum;
    logic [3:0]  tag;
    logic [4:1]  vp;
    logic [47:0] dp [1:4];

    add4simd_sched #(.TAG_W(4), .LAT(L), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst(rst), .ce(ce),
      .in_valid(in_valid & (sel == G)), .in_ready(rdy),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .flush(flush & (sel == G)),
      .simd_a(sa), .simd_b(sb), .simd_issue(iss), .simd_result(res),
      .out_valid(ov), .out_ready(out_ready & (sel == G)),
      .out_sum(sum), .out_tag(tag)
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        vp <= 4'd0;
        for (int k = 1; k <= 4; k++) dp[k] <= 48'd0;
      end else if (ce) begin
        vp    <= {vp[3:1], iss};
        dp[1] <= lane_add(sa, sb);
        for (int k = 2; k <= 4; k++) dp[k] <= dp[k-1];
      end
    end

    always_comb begin
      case (L)
        0:       res = iss   ? lane_add(sa, sb) : BAD;
        1:       res = vp[1] ? dp[1] : BAD;
        2:       res = vp[2] ? dp[2] : BAD;
        3:       res = vp[3] ? dp[3] : BAD;
        4:       res = vp[4] ? dp[4] : BAD;
        default: res = BAD;
      endcase
    end
  end

  logic        rdy_m, iss_m, ov_m;
  logic [47:0] sa_m, sb_m;
  logic [11:0] sum_m;
  logic [3:0]  tag_m;
  assign rdy_m = (sel == 2'd0) ? g_dut[0].rdy : (sel == 2'd1) ? g_dut[1].rdy : g_dut[2].rdy;
  assign iss_m = (sel == 2'd0) ? g_dut[0].iss : (sel == 2'd1) ? g_dut[1].iss : g_dut[2].iss;
  assign ov_m  = (sel == 2'd0) ? g_dut[0].ov  : (sel == 2'd1) ? g_dut[1].ov  : g_dut[2].ov;
  assign sa_m  = (sel == 2'd0) ? g_dut[0].sa  : (sel == 2'd1) ? g_dut[1].sa  : g_dut[2].sa;
  assign sb_m  = (sel == 2'd0) ? g_dut[0].sb  : (sel == 2'd1) ? g_dut[1].sb  : g_dut[2].sb;
  assign sum_m = (sel == 2'd0) ? g_dut[0].sum : (sel == 2'd1) ? g_dut[1].sum : g_dut[2].sum;
  assign tag_m = (sel == 2'd0) ? g_dut[0].tag : (sel == 2'd1) ? g_dut[1].tag : g_dut[2].tag;

  always @(posedge clk) begin
    cyc++;
    if (iss_m) issue_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [3:0] t);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    #1;
    check("in_ready_on_send", rdy_m, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input logic [11:0] es, input logic [3:0] et, input int budget);
    int w;
    w = 0;
    out_ready = 1'b1;
    while (!ov_m && w < budget) begin
      step();
      w++;
    end
    check({nm, "_valid"}, ov_m, 1);
    check({nm, "_sum"}, sum_m, es);
    check({nm, "_tag"}, tag_m, et);
    step();
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("no_extra_result", ov_m, 0);
    end
  endtask

  task automatic wait_issue(input int budget);
    int w;
    w = 0;
    while (!iss_m && w < budget) begin
      step();
      w++;
    end
    check("issue_seen", iss_m, 1);
  endtask

  logic [11:0] bp_sum [4] = '{12'h101, 12'h202, 12'h303, 12'h003};
  int ic, c0;

  initial begin
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel = 2'd0; in_a = 12'd0; in_b = 12'd0; in_tag = 4'd0;
    step(); step();
    // reset state
    check("rst_in_ready", rdy_m, 0);
    check("rst_simd_a", sa_m, 0);
    check("rst_simd_b", sb_m, 0);
    check("rst_issue", iss_m, 0);
    check("rst_out_valid", ov_m, 0);
    check("rst_out_sum", sum_m, 0);
    check("rst_out_tag", tag_m, 0);
    rst = 1'b0;
    step();

    // full batch, LAT=1
    send(12'h001, 12'h002, 4'd1);
    send(12'h003, 12'h004, 4'd2);
    send(12'h7FF, 12'h001, 4'd3);
    send(12'hFFF, 12'hFFF, 4'd4);
    ic = issue_cnt;
    check("fb_issue", iss_m, 1);
    check("fb_simd_a", sa_m, 48'h0010037FFFFF);
    check("fb_simd_b", sb_m, 48'h002004001FFF);
    check("fb_in_ready_issue", rdy_m, 0);
    collect("fb0", 12'h003, 4'd1, 5);
    collect("fb1", 12'h007, 4'd2, 0);
    collect("fb2", 12'h800, 4'd3, 0);
    collect("fb3", 12'hFFE, 4'd4, 0);
    check("fb_in_ready_after", rdy_m, 1);
    check("fb_valid_after", ov_m, 0);
    check("fb_issue_once", issue_cnt - ic, 1);

    // timeout on a single request
    ic = issue_cnt;
    send(12'h005, 12'h006, 4'd9);
    c0 = cyc;
    wait_issue(20);
    check("to_delay", cyc - c0, 8);
    check("to_simd_a", sa_m, 48'h005000000000);
    check("to_simd_b", sb_m, 48'h006000000000);
    collect("to", 12'd11, 4'd9, 5);
    expect_idle(3);
    check("to_issue_once", issue_cnt - ic, 1);

    // flush of a partial batch, then flush with nothing queued
    send(12'h00A, 12'h014, 4'd3);
    send(12'h800, 12'h800, 4'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_issue", iss_m, 1);
    check("fl_simd_a", sa_m, 48'h00A800000000);
    collect("fl0", 12'h01E, 4'd3, 5);
    collect("fl1", 12'h000, 4'd5, 0);
    expect_idle(3);
    ic = issue_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    check("fl_empty_no_issue", issue_cnt - ic, 0);
    check("fl_empty_ready", rdy_m, 1);

    // backpressure: out_ready alternates 0/1
    out_ready = 1'b0;
    send(12'h100, 12'h001, 4'd1);
    send(12'h200, 12'h002, 4'd2);
    send(12'h300, 12'h003, 4'd3);
    send(12'hFFE, 12'h005, 4'd4);
    for (int i = 0; i < 4; i++) begin
      c0 = 0;
      while (!ov_m && c0 < 5) begin
        step();
        c0++;
      end
      check("bp_valid", ov_m, 1);
      check("bp_sum", sum_m, bp_sum[i]);
      check("bp_tag", tag_m, 4'(i + 1));
      step();
      check("bp_hold_valid", ov_m, 1);
      check("bp_hold_sum", sum_m, bp_sum[i]);
      check("bp_hold_tag", tag_m, 4'(i + 1));
      check("bp_in_ready_low", rdy_m, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("bp_in_ready_after", rdy_m, 1);

    // ce stalls in WAIT and DRAIN on the LAT=4 instance
    sel = 2'd2;
    out_ready = 1'b1;
    send(12'h001, 12'h001, 4'd1);
    send(12'h002, 12'h002, 4'd2);
    send(12'h003, 12'h003, 4'd3);
    send(12'h004, 12'h004, 4'd4);
    check("ce_issue", iss_m, 1);
    step();
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ce_wait_valid", ov_m, 0);
      check("ce_wait_issue", iss_m, 0);
      check("ce_wait_ready", rdy_m, 0);
    end
    ce = 1'b1;
    collect("ce0", 12'h002, 4'd1, 10);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ce_drain_valid", ov_m, 0);
      check("ce_drain_sum", sum_m, 12'h004);
    end
    ce = 1'b1;
    #1;
    check("ce_resume_valid", ov_m, 1);
    collect("ce1", 12'h004, 4'd2, 0);
    collect("ce2", 12'h006, 4'd3, 0);
    collect("ce3", 12'h008, 4'd4, 0);

    // capture latency for LAT=0 and LAT=4
    sel = 2'd1;
    send(12'h010, 12'h020, 4'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("l0_issue", iss_m, 1);
    c0 = cyc;
    collect("l0", 12'h030, 4'd6, 10);
    check("l0_latency", cyc - c0, 2);
    sel = 2'd2;
    send(12'h111, 12'h222, 4'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("l4_issue", iss_m, 1);
    c0 = cyc;
    collect("l4", 12'h333, 4'd7, 10);
    check("l4_latency", cyc - c0, 6);

    // reset in the middle of DRAIN
    sel = 2'd0;
    send(12'h001, 12'h000, 4'd1);
    send(12'h002, 12'h000, 4'd2);
    send(12'h003, 12'h000, 4'd3);
    send(12'h004, 12'h000, 4'd4);
    collect("rd0", 12'h001, 4'd1, 5);
    collect("rd1", 12'h002, 4'd2, 0);
    check("rd_pre_valid", ov_m, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rd_async_valid", ov_m, 0);
    check("rd_async_sum", sum_m, 0);
    check("rd_async_tag", tag_m, 0);
    check("rd_async_ready", rdy_m, 0);
    check("rd_async_simd_a", sa_m, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    send(12'h123, 12'h001, 4'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("rd_new_simd_a", sa_m, 48'h123000000000);
    check("rd_new_simd_b", sb_m, 48'h001000000000);
    collect("rd_new", 12'h124, 4'd7, 5);
    expect_idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/add4simd_sched.md
Name: add4simd_sched

Overview:
- Scheduler and packer that shares one 4-lane 12-bit SIMD adder between a stream of scalar add requests.
- Collects up to four (a, b, tag) operations and packs them into the 48-bit lane words, issuing them as one SIMD operation.
- Captures the packed result after a fixed adder latency, then serialises it back into tagged scalar results.
- Sits between scalar HLS-style producers/consumers and the shared add4simd datapath.

Parameters:
TAG_W, 4, width of the request tag carried to the result.
LAT, 1, adder latency in clk cycles from issue to valid simd_result; legal range 0..4 (0 = combinational adder).
TIMEOUT, 8, cycles a partial batch (1..3 ops) waits before being issued; legal range 1..255.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
ce  in  1  clock enable; when low all state is frozen.
in_valid  in  1  scalar request valid.
in_ready  out  1  request accepted when in_valid & in_ready & ce.
in_a  in  12  operand a (two's complement).
in_b  in  12  operand b (two's complement).
in_tag  in  TAG_W  requester tag.
flush  in  1  force issue of a partial batch (level, sampled when ce=1).
simd_a  out  48  packed a to adder; lane0=[47:36], lane1=[35:24], lane2=[23:12], lane3=[11:0].
simd_b  out  48  packed b, same lane map.
simd_issue  out  1  one-cycle strobe marking a new packed operation.
simd_result  in  48  packed sums from adder, same lane map.
out_valid  out  1  scalar result valid.
out_ready  in  1  result consumed when out_valid & out_ready & ce.
out_sum  out  12  lane sum.
out_tag  out  TAG_W  tag of that lane's request.

Behaviour:
- Reset: state=FILL, count=0, timer=0, lane mask=0. All of the following are 0: in_ready, simd_a, simd_b, simd_issue, out_valid, out_sum, out_tag.
- States: FILL, ISSUE, WAIT, DRAIN. All transitions and counters advance only when ce=1.
- When ce=0: in_ready=0, out_valid=0, simd_issue=0; simd_a/simd_b hold their values.
- FILL:
  - in_ready=1.
  - Each accepted request is written into lane[count], sets mask bit count, and increments count.
  - Lanes are filled in order 0,1,2,3.
  - timer clears while count=0 and increments each ce cycle while count is 1..3.
- Leave FILL for ISSUE when any of the following holds:
  - the 4th request is accepted;
  - count>=1 and timer reaches TIMEOUT-1;
  - count>=1 and flush=1.
- flush with count=0 is ignored.
- A request accepted in the same cycle as a timeout or flush is included in the batch.
- ISSUE (1 cycle):
  - simd_issue=1, in_ready=0.
  - Unused lanes of simd_a/simd_b are driven 0.
  - simd_a/simd_b stay stable from ISSUE until the capture cycle.
- WAIT: a counter runs LAT cycles after ISSUE.
- Capture: simd_result is captured into the unpack register on the LAT-th cycle after ISSUE, then state goes to DRAIN.
  - LAT=0: capture in the ISSUE cycle itself, and WAIT is skipped.
- DRAIN:
  - Presents valid lanes in ascending lane order: out_sum=result lane, out_tag=stored tag.
  - Invalid lanes are skipped with no bubble.
  - out_valid stays high and data stays stable until the handshake.
  - After the last valid lane's handshake: count=0, mask=0, state=FILL, and in_ready=1 on the next cycle.
- Arithmetic: the block does not add. out_sum is the raw 12-bit result lane, so wrap-around is the adder's; no saturation.
- Only one batch is in flight at a time; in_ready=0 during ISSUE, WAIT and DRAIN.
- rst asserted in any state discards the batch and in-flight data immediately; all outputs return to reset values.

Test Plan:
- Full batch: 4 back-to-back requests (1+2, 3+4, 0x7FF+1, 0xFFF+0xFFF), LAT=1, out_ready=1.
  - simd_issue pulses once; simd_a=0x001_003_7FF_FFF.
  - Results, with tags, are 3, 7, 0x800, 0xFFE in order.
- Timeout: a single request 5+6, tag 9, with TIMEOUT=8.
  - ISSUE occurs 8 cycles after acceptance; lanes 1..3 are 0.
  - Exactly one result is produced: 11, tag 9.
- Flush: 2 requests, then flush=1 for one cycle → immediate ISSUE; exactly 2 results; flush with an empty batch produces no issue.
- Backpressure: a full batch with out_ready toggling 1/0 each cycle.
  - out_sum/out_tag stay stable while stalled.
  - in_ready stays 0 until the 4th result handshake.
- ce and LAT: ce low for 3 cycles during WAIT and during DRAIN freezes state and lowers out_valid; results are still correct.
  - Repeat with LAT=0 and LAT=4; capture occurs exactly LAT cycles after simd_issue.
- Reset mid-DRAIN: rst asserted after the 2nd of 4 results.
  - Outputs go to 0 asynchronously.
  - A new batch afterwards fills from lane0 with no stale results.
